// File: rtl/reg_serializer.sv
// reg_serializer: parallel-in, serial-out unloader.
// One k-bit word is taken through a valid/ready load handshake. It is then
// shifted out one bit per accepted beat on a serial valid/ready stream. A
// one-cycle done pulse follows the final bit, and the block returns to idle.
// Optional feature macro: REG_SERIALIZER_PARITY_EN appends one even-parity beat
// (the XOR of the captured word) after the k data bits.
module reg_serializer #(
  parameter int k         = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [k-1:0] in,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  input  logic         sout_ready,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(k + 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(k - 1);
`ifdef REG_SERIALIZER_PARITY_EN
  localparam logic [CW-1:0] BEAT_LAST = CW'(k);
`else
  localparam logic [CW-1:0] BEAT_LAST = CW'(k - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [k-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sout_q, sout_d;
  logic            sout_valid_q, sout_valid_d;
  logic            done_q, done_d;
`ifdef REG_SERIALIZER_PARITY_EN
  logic            parity_q, parity_d;
`endif

  // Even parity of a full word: XOR of all bits.
  function automatic logic even_parity(input logic [k-1:0] word);
    return ^word;
  endfunction

  // Next-state and next-output logic for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    done_d       = 1'b0;
`ifdef REG_SERIALIZER_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          // load_ready is 1 in IDLE, so load_valid alone completes the handshake
          shreg_d      = in;
          cnt_d        = '0;
          sout_d       = MSB_FIRST ? in[k-1] : in[0];
          sout_valid_d = 1'b1;
          state_d      = ST_SHIFT;
`ifdef REG_SERIALIZER_PARITY_EN
          parity_d     = even_parity(in);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sout_valid_q && sout_ready) begin
          if (cnt_q == BEAT_LAST) begin
            sout_valid_d = 1'b0;
            sout_d       = 1'b0;
            done_d       = 1'b1;
            state_d      = ST_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
            // Present the next data bit; the word only ever moves by shifting
            if (MSB_FIRST) begin
              shreg_d = {shreg_q[k-2:0], 1'b0};
              sout_d  = shreg_q[k-2];
            end else begin
              shreg_d = {1'b0, shreg_q[k-1:1]};
              sout_d  = shreg_q[1];
            end
`ifdef REG_SERIALIZER_PARITY_EN
            // After the last data bit, the stored parity becomes the extra beat
            if (cnt_q == DATA_LAST) begin
              sout_d = parity_q;
            end else begin
              sout_d = sout_d;
            end
`endif
          end
        end else begin
          // Stalled: hold the current bit, valid and count
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d      = ST_IDLE;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; asynchronous clear to an empty IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef REG_SERIALIZER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
`ifdef REG_SERIALIZER_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;

  // DATA_LAST only matters when the parity beat is present
  logic unused_s;
  assign unused_s = ^DATA_LAST;

endmodule

// File: tb/tb_reg_serializer.sv
// Bench for reg_serializer: an MSB-first and an LSB-first instance share all inputs.
// A word-level model (captured word + beat index) predicts every output each cycle;
// directed tests pin the model with hand-computed stream values.
module tb_reg_serializer;

`ifdef REG_SERIALIZER_PARITY_EN
  localparam int LEN = 17;
`else
  localparam int LEN = 16;
`endif
  localparam int DONE_CYC = LEN + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in = 16'h0000;
  logic        load_valid = 1'b0;
  logic        sout_ready = 1'b0;
  logic        load_ready0, sout0, sout_valid0, busy0, done0;
  logic        load_ready1, sout1, sout_valid1, busy1, done1;

  int checks = 0;
  int errors = 0;

  logic [LEN-1:0] cap0 = '0;
  logic [LEN-1:0] cap1 = '0;

  // word-level model state
  int          ph = 0;   // 0 idle, 1 streaming, 2 done
  int          b  = 0;   // beat index currently presented
  logic [15:0] w  = 16'h0000;

  reg_serializer #(.k(16), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .reset(reset), .in(in), .load_valid(load_valid),
    .load_ready(load_ready0), .sout(sout0), .sout_valid(sout_valid0),
    .sout_ready(sout_ready), .busy(busy0), .done(done0));

  reg_serializer #(.k(16), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset(reset), .in(in), .load_valid(load_valid),
    .load_ready(load_ready1), .sout(sout1), .sout_valid(sout_valid1),
    .sout_ready(sout_ready), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [LEN-1:0] expc(input logic [15:0] word, input logic p);
    logic [16:0] full;
    full = {word, p};
    return full[16 -: LEN];
  endfunction

  function automatic logic model_bit(input bit msb);
    if (b < 16) return msb ? w[15 - b] : w[b];
    return ^w;
  endfunction

  // model: advances per posedge from the applied inputs, cleared by reset
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        ph = 0; b = 0;
      end else begin
        case (ph)
          0: if (load_valid) begin w = in; b = 0; ph = 1; end
          1: if (sout_ready) begin b++; if (b == LEN) ph = 2; end
          default: ph = 0;
        endcase
      end
    end
  end

  // compare process: every negedge, both DUTs against the model; records streams
  initial begin
    forever begin
      @(negedge clk);
      chk("load_ready0", load_ready0, (ph == 0));
      chk("busy0",       busy0,       (ph != 0));
      chk("done0",       done0,       (ph == 2));
      chk("sout_valid0", sout_valid0, (ph == 1));
      chk("sout0",       sout0,       (ph == 1) ? model_bit(1'b1) : 1'b0);
      chk("load_ready1", load_ready1, (ph == 0));
      chk("busy1",       busy1,       (ph != 0));
      chk("done1",       done1,       (ph == 2));
      chk("sout_valid1", sout_valid1, (ph == 1));
      chk("sout1",       sout1,       (ph == 1) ? model_bit(1'b0) : 1'b0);
      if (load_valid && load_ready0) begin
        cap0 = '0; cap1 = '0;
      end
      if (sout_valid0 && sout_ready) cap0 = {cap0[LEN-2:0], sout0};
      if (sout_valid1 && sout_ready) cap1 = {cap1[LEN-2:0], sout1};
    end
  end

  // Load a word from IDLE; optional 4-cycle stall and optional held FFFF reload.
  task automatic send(input logic [15:0] word, input int stall_at, input bit hold_ff,
                      output int dcyc);
    bit stalled;
    in = word; load_valid = 1'b1; sout_ready = 1'b1; dcyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        if (hold_ff) in = 16'hFFFF;
        else load_valid = 1'b0;
      end
      stalled = (stall_at > 0) && (c >= stall_at) && (c < stall_at + 4);
      sout_ready = !stalled;
      if (stalled) begin
        chk("stall_sout", sout0, 32'd0);
        chk("stall_valid", sout_valid0, 32'd1);
      end
      if (hold_ff && c == 5) chk("hold_load_ready", load_ready0, 32'd0);
      if (done0) begin dcyc = c; break; end
    end
    if (dcyc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic after_done();
    @(posedge clk); #1;
    chk("done_single", done0, 32'd0);
    chk("ready_back", load_ready0, 32'd1);
  endtask

  initial begin
    int dc;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_sout", sout0, 32'd0);
    chk("rst_valid", sout_valid0, 32'd0);
    chk("rst_done", done0, 32'd0);
    chk("rst_busy", busy0, 32'd0);
    chk("rst_ready", load_ready0, 32'd1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // plain A5C3 stream
    send(16'hA5C3, 0, 1'b0, dc);
    chk("a5c3_done_cyc", dc, DONE_CYC);
    chk("a5c3_msb", cap0, expc(16'hA5C3, 1'b0));
    chk("a5c3_lsb", cap1, expc(16'hC3A5, 1'b0));
    after_done();

    // stall while bit index 3 is presented
    send(16'hA5C3, 4, 1'b0, dc);
    chk("stall_done_cyc", dc, DONE_CYC + 4);
    chk("stall_msb", cap0, expc(16'hA5C3, 1'b0));
    after_done();

    // FFFF held during SHIFT: ignored, then accepted from IDLE
    send(16'hA5C3, 0, 1'b1, dc);
    chk("hold_done_cyc", dc, DONE_CYC);
    chk("hold_stream", cap0, expc(16'hA5C3, 1'b0));
    after_done();
    send(16'hFFFF, 0, 1'b0, dc);
    chk("ffff_stream", cap0, expc(16'hFFFF, 1'b0));
    after_done();

    // reset after the 7th beat
    in = 16'hA5C3; load_valid = 1'b1; sout_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) load_valid = 1'b0;
    end
    reset = 1'b0; #1;
    chk("mid_rst_sout", sout0, 32'd0);
    chk("mid_rst_valid", sout_valid0, 32'd0);
    chk("mid_rst_done", done0, 32'd0);
    chk("mid_rst_busy", busy0, 32'd0);
    chk("mid_rst_busy1", busy1, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_no_done", done0, 32'd0);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    send(16'h00FF, 0, 1'b0, dc);
    chk("00ff_msb", cap0, expc(16'h00FF, 1'b0));
    chk("00ff_lsb", cap1, expc(16'hFF00, 1'b0));
    after_done();

    // single set bit: LSB-first sends 1 then zeros
    send(16'h0001, 0, 1'b0, dc);
    chk("0001_lsb", cap1, expc(16'h8000, 1'b1));
    chk("0001_msb", cap0, expc(16'h0001, 1'b1));
    chk("0001_done_cyc", dc, DONE_CYC);
    after_done();

    send(16'h0003, 0, 1'b0, dc);
    chk("0003_msb", cap0, expc(16'h0003, 1'b0));
    chk("0003_lsb", cap1, expc(16'hC000, 1'b0));
    after_done();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
